// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared format and underrun-policy constants for the I2S transmitter
// Purpose : encodings of the fmt_lj and udr_repeat control inputs.
// Ports   : none (package).
package i2s_pkg;

   localparam logic FMT_I2S    = 1'b0;  // MSB one SCK after the WS edge
   localparam logic FMT_LJ     = 1'b1;  // MSB on the WS edge

   localparam logic UDR_ZERO   = 1'b0;  // underrun transmits silence
   localparam logic UDR_REPEAT = 1'b1;  // underrun retransmits the last frame

endpackage

// File: rtl/i2s_tx_mc_fifo.sv
// rtl/i2s_tx_mc_fifo.sv - parameterised show-ahead synchronous FIFO
// Purpose : frame storage between the upstream filter and the serializer.
// Ports   : clk, rst_n (async active-low)
//           wr_en/wr_data  - write request, ignored when full
//           rd_en/rd_data  - pop request (ignored when empty), rd_data shows the head entry
//           full, empty, level - occupancy status
module i2s_tx_mc_fifo #(
   parameter int WIDTH = 32,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      level
);

   localparam int          DEPTH    = 1 << AW;
   localparam logic [AW:0] FULL_LVL = {1'b1, {AW{1'b0}}};

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             wr_ok;
   logic             rd_ok;

   assign full    = (level == FULL_LVL);
   assign empty   = (level == '0);
   assign wr_ok   = wr_en && !full;
   assign rd_ok   = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   // Storage array carries no reset; validity is tracked by level alone.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (wr_ok && !rd_ok) begin
            level <= level + 1'b1;
         end else if (!wr_ok && rd_ok) begin
            level <= level - 1'b1;
         end
      end
   end

endmodule

// File: rtl/i2s_tx_mc.sv
// rtl/i2s_tx_mc.sv - I2S / left-justified stereo transmitter with frame FIFO
// Purpose : buffers {left,right} frames and serializes them MSB first, one bit per SCK falling edge.
// Ports   : clk, rst_n (async active-low)
//           i2so_sync_sck, i2so_sck_transition - synchronised SCK and its falling-edge strobe
//           en, fmt_lj, udr_repeat             - serializer enable, data format, underrun policy
//           filt_rts/filt_rtr/filt_data        - upstream frame handshake
//           i2so_sck, i2so_ws, i2so_sd         - serial outputs
//           fifo_level                          - FIFO occupancy
//           trig_fifo_underrun/ro_fifo_underrun - sticky underrun flag and its clear strobe
module i2s_tx_mc
   import i2s_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int SLOT_W  = 32,
   parameter int FIFO_AW = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i2so_sync_sck,
   input  logic                i2so_sck_transition,
   input  logic                en,
   input  logic                fmt_lj,
   input  logic                udr_repeat,
   input  logic                filt_rts,
   output logic                filt_rtr,
   input  logic [2*DATA_W-1:0] filt_data,
   output logic                i2so_sck,
   output logic                i2so_ws,
   output logic                i2so_sd,
   output logic [FIFO_AW:0]    fifo_level,
   input  logic                trig_fifo_underrun,
   output logic                ro_fifo_underrun
);

   localparam int              FW       = 2 * DATA_W;
   localparam int              CW       = $clog2(2 * SLOT_W);
   localparam logic [CW-1:0]   CNT_LAST = CW'(2 * SLOT_W - 1);
   localparam logic [CW-1:0]   CNT_SLOT = CW'(SLOT_W);
   localparam logic [DATA_W-1:0] BIT0   = {{(DATA_W-1){1'b0}}, 1'b1};

   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_pop;
   logic [FW-1:0]     fifo_rd_data;

   logic [CW-1:0]     bcnt;
   logic [CW-1:0]     nxt_cnt;
   logic              run;        // a frame is in progress since en rose
   logic              lj_q;       // format latched at the last fetch
   logic [FW-1:0]     cur;        // frame being sent, also the repeat source on underrun
   logic              fetch;
   logic [FW-1:0]     fetched;
   logic [FW-1:0]     nxt_frame;
   logic              nxt_lj;
   logic              nxt_ws;
   logic              nxt_sd;
   int                k;
   logic [DATA_W-1:0] word;
   logic              prev_lsb;

   assign i2so_sck = i2so_sync_sck;
   assign filt_rtr = !fifo_full;

   i2s_tx_mc_fifo #(
      .WIDTH (FW),
      .AW    (FIFO_AW)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (filt_rts),
      .wr_data (filt_data),
      .rd_en   (fifo_pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   // Next bit position and frame fetch. A serializer that is not yet running
   // restarts at count 0, which makes the first pulse after en rises a fetch.
   always_comb begin
      if (!run || bcnt == CNT_LAST) begin
         nxt_cnt = '0;
      end else begin
         nxt_cnt = bcnt + 1'b1;
      end
      fetch    = en && i2so_sck_transition && (nxt_cnt == '0);
      fifo_pop = fetch && !fifo_empty;
      if (!fifo_empty) begin
         fetched = fifo_rd_data;
      end else if (udr_repeat == UDR_REPEAT) begin
         fetched = cur;
      end else begin
         fetched = '0;
      end
      nxt_frame = fetch ? fetched : cur;
      nxt_lj    = fetch ? fmt_lj : lj_q;
      nxt_ws    = (nxt_cnt >= CNT_SLOT);
   end

   // Bit to drive at the next count, from the slot-relative position k.
   always_comb begin
      k = int'(nxt_cnt);
      if (nxt_ws) begin
         k = k - SLOT_W;
      end
      word = nxt_ws ? nxt_frame[DATA_W-1:0] : nxt_frame[FW-1:DATA_W];
      // In I2S mode a full-width slot lets the previous slot's LSB spill into
      // position 0: the left LSB of this frame, or the right LSB of the old one.
      prev_lsb = nxt_ws ? nxt_frame[DATA_W] : cur[0];
      nxt_sd   = 1'b0;
      if (nxt_lj == FMT_LJ) begin
         if (k < DATA_W) begin
            nxt_sd = |(word & (BIT0 << (DATA_W - 1 - k)));
         end
      end else begin
         if (k >= 1 && k <= DATA_W) begin
            nxt_sd = |(word & (BIT0 << (DATA_W - k)));
         end else if (k == 0 && DATA_W == SLOT_W) begin
            nxt_sd = prev_lsb;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcnt             <= '0;
         run              <= 1'b0;
         lj_q             <= FMT_I2S;
         cur              <= '0;
         i2so_ws          <= 1'b0;
         i2so_sd          <= 1'b0;
         ro_fifo_underrun <= 1'b0;
      end else begin
         // Setting has priority over the clear strobe.
         if (fetch && fifo_empty) begin
            ro_fifo_underrun <= 1'b1;
         end else if (trig_fifo_underrun) begin
            ro_fifo_underrun <= 1'b0;
         end

         if (!en) begin
            run     <= 1'b0;
            bcnt    <= '0;
            i2so_ws <= 1'b0;
            i2so_sd <= 1'b0;
         end else if (i2so_sck_transition) begin
            run     <= 1'b1;
            bcnt    <= nxt_cnt;
            i2so_ws <= nxt_ws;
            i2so_sd <= nxt_sd;
            cur     <= nxt_frame;
            lj_q    <= nxt_lj;
         end
      end
   end

endmodule

// File: tb/tb_i2s_tx_mc.sv
// tb/tb_i2s_tx_mc.sv - self-checking bench for i2s_tx_mc
module tb_i2s_tx_mc;

   localparam int DATA_W  = 16;
   localparam int SLOT_W  = 32;
   localparam int FIFO_AW = 3;
   localparam logic [63:0] WS_EXP = 64'h0000_0000_FFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sync_sck;
   logic        trans;
   logic        en;
   logic        fmt_lj;
   logic        udr_repeat;
   logic        filt_rts;
   logic        filt_rtr;
   logic [31:0] filt_data;
   logic        sck;
   logic        ws;
   logic        sd;
   logic [3:0]  fifo_level;
   logic        trig;
   logic        udr;

   int vecs = 0;
   int errs = 0;

   typedef struct {
      logic [31:0] frame;
      logic        lj;
      logic [63:0] exp_sd;
   } vec_t;

   vec_t tbl[6];

   always #5 clk = ~clk;

   i2s_tx_mc #(
      .DATA_W  (DATA_W),
      .SLOT_W  (SLOT_W),
      .FIFO_AW (FIFO_AW)
   ) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .i2so_sync_sck       (sync_sck),
      .i2so_sck_transition (trans),
      .en                  (en),
      .fmt_lj              (fmt_lj),
      .udr_repeat          (udr_repeat),
      .filt_rts            (filt_rts),
      .filt_rtr            (filt_rtr),
      .filt_data           (filt_data),
      .i2so_sck            (sck),
      .i2so_ws             (ws),
      .i2so_sd             (sd),
      .fifo_level          (fifo_level),
      .trig_fifo_underrun  (trig),
      .ro_fifo_underrun    (udr)
   );

   // Expected 64-count serial stream, MSB first (bit 63 = count 0).
   function automatic logic [63:0] model_stream(input logic [31:0] f, input logic lj);
      logic [15:0] l;
      logic [15:0] r;
      l = f[31:16];
      r = f[15:0];
      if (lj) begin
         return {l, 16'h0, r, 16'h0};
      end
      return {1'b0, l, 15'h0, 1'b0, r, 15'h0};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic write_frame(input logic [31:0] f);
      filt_data = f;
      filt_rts  = 1'b1;
      tick();
      filt_rts  = 1'b0;
   endtask

   task automatic sck_pulse(input logic with_trig);
      sync_sck = 1'b1;
      tick();
      tick();
      sync_sck = 1'b0;
      trans    = 1'b1;
      trig     = with_trig;
      tick();
      trans    = 1'b0;
      trig     = 1'b0;
      tick();
   endtask

   task automatic capture_frame(input logic trig_first, input int flip_at,
                                output logic [63:0] s, output logic [63:0] w);
      s = '0;
      w = '0;
      for (int c = 0; c < 64; c++) begin
         if (c == flip_at) fmt_lj = ~fmt_lj;
         sck_pulse(trig_first && (c == 0));
         s = {s[62:0], sd};
         w = {w[62:0], ws};
      end
   endtask

   task automatic do_reset();
      en       = 1'b0;
      trans    = 1'b0;
      trig     = 1'b0;
      filt_rts = 1'b0;
      rst_n    = 1'b0;
      tick();
      rst_n    = 1'b1;
      tick();
   endtask

   task automatic run_vec(input string name, input logic [31:0] f, input logic lj,
                          input logic [63:0] exp_sd);
      logic [63:0] s;
      logic [63:0] w;
      write_frame(f);
      chk({name, "_level1"}, 64'(fifo_level), 64'd1);
      fmt_lj = lj;
      en     = 1'b1;
      capture_frame(1'b0, -1, s, w);
      en     = 1'b0;
      tick();
      chk({name, "_sd"}, s, exp_sd);
      chk({name, "_ws"}, w, WS_EXP);
      chk({name, "_udr"}, 64'(udr), 64'd0);
      chk({name, "_level0"}, 64'(fifo_level), 64'd0);
      chk({name, "_idle"}, 64'({ws, sd}), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [63:0] s;
      logic [63:0] w;
      logic [31:0] f;
      logic        lj;
      logic [31:0] q[$];

      rst_n      = 1'b0;
      sync_sck   = 1'b0;
      trans      = 1'b0;
      en         = 1'b0;
      fmt_lj     = 1'b0;
      udr_repeat = 1'b0;
      filt_rts   = 1'b0;
      filt_data  = '0;
      trig       = 1'b0;
      tick();
      tick();

      chk("reset_ws", 64'(ws), 64'd0);
      chk("reset_sd", 64'(sd), 64'd0);
      chk("reset_udr", 64'(udr), 64'd0);
      chk("reset_level", 64'(fifo_level), 64'd0);
      chk("reset_rtr", 64'(filt_rtr), 64'd1);
      sync_sck = 1'b1;
      #1;
      chk("sck_pass_hi", 64'(sck), 64'd1);
      sync_sck = 1'b0;
      #1;
      chk("sck_pass_lo", 64'(sck), 64'd0);
      rst_n = 1'b1;
      tick();

      // Single-frame vectors with hand-derived streams.
      tbl[0] = '{32'hA5A5_3C3C, 1'b0, {1'b0, 16'hA5A5, 15'h0, 1'b0, 16'h3C3C, 15'h0}};
      tbl[1] = '{32'hA5A5_3C3C, 1'b1, {16'hA5A5, 16'h0, 16'h3C3C, 16'h0}};
      tbl[2] = '{32'h1234_5678, 1'b0, {1'b0, 16'h1234, 15'h0, 1'b0, 16'h5678, 15'h0}};
      tbl[3] = '{32'hFFFF_0001, 1'b1, {16'hFFFF, 16'h0, 16'h0001, 16'h0}};
      tbl[4] = '{32'h8000_FFFF, 1'b0, {1'b0, 16'h8000, 15'h0, 1'b0, 16'hFFFF, 15'h0}};
      tbl[5] = '{32'h0000_0000, 1'b1, 64'h0};
      for (int i = 0; i < 6; i++) begin
         run_vec($sformatf("tbl%0d", i), tbl[i].frame, tbl[i].lj, tbl[i].exp_sd);
      end

      // Random single frames against the model.
      for (int i = 0; i < 6; i++) begin
         f  = $urandom;
         lj = 1'($urandom_range(0, 1));
         run_vec($sformatf("rnd%0d", i), f, lj, model_stream(f, lj));
      end

      // Back-to-back frames; format toggled mid-frame must not apply until the next fetch.
      do_reset();
      q = {};
      for (int i = 0; i < 5; i++) begin
         f = $urandom;
         q.push_back(f);
         write_frame(f);
      end
      chk("stream_level5", 64'(fifo_level), 64'd5);
      en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         lj     = 1'($urandom_range(0, 1));
         fmt_lj = lj;
         capture_frame(1'b0, 20, s, w);
         chk($sformatf("stream%0d_sd", i), s, model_stream(q[i], lj));
         chk($sformatf("stream%0d_ws", i), w, WS_EXP);
      end
      en = 1'b0;
      tick();
      chk("stream_udr", 64'(udr), 64'd0);
      chk("stream_level0", 64'(fifo_level), 64'd0);

      // Write and pop on the same clock, then fill to full.
      do_reset();
      for (int i = 0; i < 3; i++) write_frame($urandom);
      en        = 1'b1;
      filt_data = $urandom;
      filt_rts  = 1'b1;
      sync_sck  = 1'b0;
      trans     = 1'b1;
      tick();
      filt_rts  = 1'b0;
      trans     = 1'b0;
      chk("wr_pop_level", 64'(fifo_level), 64'd3);
      en = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) write_frame($urandom);
      chk("full_level", 64'(fifo_level), 64'd8);
      chk("full_rtr", 64'(filt_rtr), 64'd0);
      write_frame(32'hDEAD_BEEF);
      chk("full_no_write", 64'(fifo_level), 64'd8);
      en    = 1'b1;
      trans = 1'b1;
      tick();
      trans = 1'b0;
      chk("pop_rtr", 64'(filt_rtr), 64'd1);
      chk("pop_level", 64'(fifo_level), 64'd7);
      en = 1'b0;
      tick();

      // Underrun: repeat last frame, clear, then set-wins and zero fill.
      do_reset();
      udr_repeat = 1'b1;
      fmt_lj     = 1'b0;
      write_frame(32'h1234_5678);
      en = 1'b1;
      capture_frame(1'b0, -1, s, w);
      chk("udr_first_sd", s, model_stream(32'h1234_5678, 1'b0));
      chk("udr_first_flag", 64'(udr), 64'd0);
      capture_frame(1'b0, -1, s, w);
      chk("udr_repeat_sd", s, model_stream(32'h1234_5678, 1'b0));
      chk("udr_repeat_flag", 64'(udr), 64'd1);
      trig = 1'b1;
      tick();
      trig = 1'b0;
      chk("udr_cleared", 64'(udr), 64'd0);
      udr_repeat = 1'b0;
      capture_frame(1'b1, -1, s, w);
      chk("udr_set_wins", 64'(udr), 64'd1);
      chk("udr_zero_sd", s, 64'h0);
      chk("udr_zero_ws", w, WS_EXP);
      en = 1'b0;
      tick();

      // Reset mid-frame with frames queued.
      do_reset();
      for (int i = 0; i < 3; i++) write_frame($urandom);
      fmt_lj = 1'b0;
      en     = 1'b1;
      for (int c = 0; c <= 20; c++) sck_pulse(1'b0);
      chk("pre_rst_level", 64'(fifo_level), 64'd2);
      rst_n = 1'b0;
      #1;
      chk("midrst_ws", 64'(ws), 64'd0);
      chk("midrst_sd", 64'(sd), 64'd0);
      chk("midrst_udr", 64'(udr), 64'd0);
      chk("midrst_level", 64'(fifo_level), 64'd0);
      chk("midrst_rtr", 64'(filt_rtr), 64'd1);
      tick();
      rst_n = 1'b1;
      tick();
      chk("postrst_level", 64'(fifo_level), 64'd0);
      write_frame(32'hC0DE_0F0F);
      capture_frame(1'b0, -1, s, w);
      chk("postrst_sd", s, model_stream(32'hC0DE_0F0F, 1'b0));
      chk("postrst_ws", w, WS_EXP);
      chk("postrst_udr", 64'(udr), 64'd0);
      en = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
